// File: rtl/spi_program_fetch.sv
// spi_program_fetch: loads a program over slave SPI into a local memory,
// then sequences it into the execution unit one instruction per clk.
//
// Ports:
//   clk, reset        system clock, async active-high reset
//   spi_sclk/cs_n/mosi SPI mode-0 slave inputs (async to clk)
//   run, loop         start execution / wrap at end of program
//   opcode, operand   instruction to execution unit (operand[7:4]=A, [3:0]=B)
//   start             opcode/operand carry a valid instruction
//   busy, halted      status: LOAD or RUN / HALT
//   overflow          sticky: a word arrived with memory full
//   prog_len          words stored by the last completed load
module spi_program_fetch #(
    parameter int                          ROM_ADDRESS_WIDTH = 5,
    parameter int                          INPUT_DATA_WIDTH  = 4,
    parameter logic [INPUT_DATA_WIDTH-1:0] NOP_OPCODE        = 4'h0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            spi_sclk,
    input  logic                            spi_cs_n,
    input  logic                            spi_mosi,
    input  logic                            run,
    input  logic                            loop,
    output logic [INPUT_DATA_WIDTH-1:0]     opcode,
    output logic [2*INPUT_DATA_WIDTH-1:0]   operand,
    output logic                            start,
    output logic                            busy,
    output logic                            halted,
    output logic                            overflow,
    output logic [ROM_ADDRESS_WIDTH:0]      prog_len
);

    localparam int AW    = ROM_ADDRESS_WIDTH;
    localparam int DW    = INPUT_DATA_WIDTH;
    localparam int PW    = AW + 1;
    localparam int WW    = 3 * DW;
    localparam int BW    = $clog2(WW + 1);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HALT
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     pc_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [BW-1:0]     bcnt_q;
    logic [WW-1:0]     sr_q;
    logic [PW-1:0]     prog_len_q;
    logic              overflow_q;
    logic [DW-1:0]     opcode_q;
    logic [2*DW-1:0]   operand_q;
    logic              start_q;
    logic [WW-1:0]     mem_q [DEPTH];

    logic [1:0]        sclk_sync_q;
    logic [1:0]        cs_sync_q;
    logic [1:0]        mosi_sync_q;
    logic              sclk_prev_q;
    logic              cs_prev_q;

    logic              sclk_rise;
    logic              cs_fall;
    logic              cs_rise;
    logic              commit;
    logic              full;
    logic [PW-1:0]     ptr_d;
    logic [AW-1:0]     rd_addr;
    logic [WW-1:0]     rd_word;
    logic              last;
    logic              issue;

    // cs_n chain resets high so reset release never looks like a select
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sclk_prev_q <= sclk_sync_q[1];
            cs_prev_q   <= cs_sync_q[1];
        end
    end

    always_comb begin
        sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
        cs_fall   = ~cs_sync_q[1] & cs_prev_q;
        cs_rise   = cs_sync_q[1] & ~cs_prev_q;
        commit    = (bcnt_q == BW'(WW));
        full      = (wr_ptr_q == PW'(DEPTH));
        // includes a word committing in the same cycle cs_n rises
        ptr_d     = wr_ptr_q + PW'(commit && !full);
        // the run-sampling cycle issues word 0 straight away
        rd_addr   = (state_q == S_RUN) ? pc_q : '0;
        rd_word   = mem_q[rd_addr];
        last      = (({1'b0, rd_addr} + PW'(1)) == prog_len_q);
        issue     = ~cs_fall &
                    ((state_q == S_RUN) |
                     (((state_q == S_IDLE) | (state_q == S_HALT)) &
                      run & (prog_len_q != '0)));
    end

    // program memory is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && commit && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= sr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            wr_ptr_q   <= '0;
            bcnt_q     <= '0;
            sr_q       <= '0;
            prog_len_q <= '0;
            overflow_q <= 1'b0;
            opcode_q   <= NOP_OPCODE;
            operand_q  <= '0;
            start_q    <= 1'b0;
        end else begin
            opcode_q  <= NOP_OPCODE;
            operand_q <= '0;
            start_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (cs_fall) begin
                        state_q    <= S_LOAD;
                        wr_ptr_q   <= '0;
                        bcnt_q     <= '0;
                        overflow_q <= 1'b0;
                    end else if (run && prog_len_q == '0) begin
                        state_q <= S_HALT;
                    end
                end
                S_LOAD: begin
                    if (commit) begin
                        bcnt_q   <= '0;
                        wr_ptr_q <= ptr_d;
                        if (full) begin
                            overflow_q <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        sr_q   <= {sr_q[WW-2:0], mosi_sync_q[1]};
                        bcnt_q <= bcnt_q + BW'(1);
                    end
                    // a partial word is simply not counted
                    if (cs_rise) begin
                        prog_len_q <= ptr_d;
                        state_q    <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (cs_fall) begin
                        state_q    <= S_LOAD;
                        wr_ptr_q   <= '0;
                        bcnt_q     <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (issue) begin
                opcode_q  <= rd_word[WW-1 -: DW];
                operand_q <= rd_word[2*DW-1:0];
                start_q   <= 1'b1;
                if (last) begin
                    pc_q    <= '0;
                    state_q <= loop ? S_RUN : S_HALT;
                end else begin
                    pc_q    <= rd_addr + AW'(1);
                    state_q <= S_RUN;
                end
            end
        end
    end

    assign opcode   = opcode_q;
    assign operand  = operand_q;
    assign start    = start_q;
    assign busy     = (state_q == S_LOAD) || (state_q == S_RUN);
    assign halted   = (state_q == S_HALT);
    assign overflow = overflow_q;
    assign prog_len = prog_len_q;

endmodule

// File: doc/spi_program_fetch.md
Name: spi_program_fetch

Overview:
- Upstream stage of the execution unit.
- Receives a program over a slave SPI link and stores it in an internal program memory of 2^ROM_ADDRESS_WIDTH words, each word being a 4-bit opcode plus an 8-bit operand.
- On command, sequences the stored program through a program counter. Each cycle it drives opcode, operand and start directly into the execution unit.
- Also reports load/run status to top-level I/O.

Parameters:
- ROM_ADDRESS_WIDTH, 5, program memory address width; depth = 2^ROM_ADDRESS_WIDTH words.
- INPUT_DATA_WIDTH, 4, opcode width; operand width = 2*INPUT_DATA_WIDTH; SPI word = 3*INPUT_DATA_WIDTH bits.
- NOP_OPCODE, 4'h0, opcode driven whenever no instruction is issued.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- spi_sclk  input  1  SPI clock (mode 0), asynchronous to clk.
- spi_cs_n  input  1  SPI chip select, active-low, asynchronous.
- spi_mosi  input  1  SPI data in, MSB first, asynchronous.
- run  input  1  level; starts execution when sampled high in IDLE or HALT.
- loop  input  1  1 = wrap pc to 0 after last instruction; 0 = halt.
- opcode  output  INPUT_DATA_WIDTH  to execution unit opcode.
- operand  output  2*INPUT_DATA_WIDTH  to execution unit operand; [7:4] = A, [3:0] = B.
- start  output  1  high for exactly the cycles in which opcode/operand carry a valid instruction.
- busy  output  1  high in LOAD or RUN.
- halted  output  1  high in HALT.
- overflow  output  1  sticky; a word arrived with memory full.
- prog_len  output  ROM_ADDRESS_WIDTH+1  number of words stored by the last load.

Behaviour:
- Reset values: opcode = NOP_OPCODE, operand = 0, start = 0, busy = 0, halted = 0, overflow = 0, prog_len = 0, state = IDLE. Memory contents are not reset.
- Synchronisation:
  - spi_sclk, spi_cs_n and spi_mosi each pass through a 2-flop synchroniser; all three share the same depth.
  - A sclk rising edge is detected as sync=1 with previous=0; mosi is sampled in the same cycle.
  - Supported range: spi_sclk <= clk/8.
- Shift register:
  - 12-bit shifter plus a 4-bit bit count; shift is {sr[10:0], mosi}.
  - At bit count 12, sr is written to mem[wr_ptr], wr_ptr increments and the bit count returns to 0.
  - When wr_ptr = depth, the word is dropped and overflow is set.
- FSM:
  - IDLE: synced cs_n falling → LOAD (wr_ptr = 0, bit count = 0, overflow cleared). run=1 → RUN with pc = 0.
  - LOAD: shift as above. Synced cs_n rising → prog_len = wr_ptr, go IDLE. A partial word (bit count != 0) is discarded.
  - RUN:
    - Each cycle: opcode/operand = mem[pc] (registered), start = 1, pc increments.
    - When issuing pc = prog_len-1: if loop, next pc = 0 and stay in RUN; else go HALT next cycle.
    - Latency: the first instruction appears the cycle after run is sampled.
    - Issue rate: one instruction per clk.
  - HALT: start = 0, opcode = NOP_OPCODE, operand = 0. run=1 → RUN from pc = 0. cs_n falling → LOAD.
- Boundary cases:
  - prog_len = 0 with run=1 → HALT directly; start never asserts.
  - cs_n falling during RUN aborts execution: the next cycle has start = 0 and state = LOAD. cs_n takes priority over run.
  - run held high in HALT restarts execution immediately (free-running repeat).
  - Reset mid-load or mid-run returns to IDLE. prog_len = 0 until a new load completes.
  - Outside RUN, opcode/operand/start always hold their idle values.

Test Plan:
- Load 3 words 0x1AB, 0x2CD, 0x3EF with loop=0, then pulse run. Required: prog_len = 3. Three consecutive cycles with start = 1 carrying opcode/operand 1/AB, 2/CD, 3/EF. Then start = 0 and halted = 1.
- Same program with loop=1 and run held. Required: repeating sequence 1,2,3,1,2,3 with start continuously high.
- Load 33 words. Required: overflow = 1, prog_len = 32, and mem[31] holds word 32.
- Load 2 words plus 5 extra bits, then raise cs_n. Required: prog_len = 2 and only 2 instructions issue.
- run with prog_len = 0 after reset. Required: halted = 1 and start never high.
- Assert reset mid-run on the 2nd instruction. Required: outputs return to reset values asynchronously; halted = 0 and busy = 0.
